// File: rtl/fft_sample_loader.sv
// FFT front-end loader: writes a frame of real samples into the FFT working RAM
// at bit-reversed addresses, starts the FFT engine, and waits for it to finish.
module fft_sample_loader #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned MUTI       = 1,
    parameter int unsigned IN_SHIFT   = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           en,
    input  logic [DATA_WIDTH-1:0]          s_data,
    input  logic                           s_valid,
    output logic                           s_ready,
    output logic                           ram_wen,
    output logic [ADDR_WIDTH-1:0]          ram_waddr,
    output logic [2*MUTI*DATA_WIDTH-1:0]   ram_wdata,
    output logic                           ram_sel,
    output logic                           fft_start,
    input  logic                           fft_done,
    output logic                           busy,
    output logic [15:0]                    frame_cnt
);

    localparam int unsigned HALF_WIDTH = MUTI * DATA_WIDTH;
    localparam int unsigned WORD_WIDTH = 2 * HALF_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        START,
        BUSY
    } state_t;

    state_t                  state, state_d;
    logic [ADDR_WIDTH-1:0]   cnt, cnt_d;
    logic                    ram_wen_d;
    logic [ADDR_WIDTH-1:0]   ram_waddr_d;
    logic [WORD_WIDTH-1:0]   ram_wdata_d;
    logic                    ram_sel_d;
    logic                    fft_start_d;
    logic                    busy_d;
    logic [15:0]             frame_cnt_d;

    logic signed [DATA_WIDTH-1:0] shifted;
    logic signed [HALF_WIDTH-1:0] real_ext;

    function automatic logic [ADDR_WIDTH-1:0] bitrev(input logic [ADDR_WIDTH-1:0] v);
        logic [ADDR_WIDTH-1:0] r;
        for (int i = 0; i < int'(ADDR_WIDTH); i++) begin
            r[i] = v[int'(ADDR_WIDTH) - 1 - i];
        end
        return r;
    endfunction

    assign s_ready  = (state == LOAD) & en;
    assign shifted  = $signed(s_data) >>> IN_SHIFT;
    assign real_ext = HALF_WIDTH'(shifted);

    // Next-state and next-output logic; START spends one cycle arming the pulse, one firing it.
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        ram_wen_d   = 1'b0;
        ram_waddr_d = ram_waddr;
        ram_wdata_d = ram_wdata;
        fft_start_d = 1'b0;
        frame_cnt_d = frame_cnt;

        case (state)
            IDLE: begin
                if (en) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (!en) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (s_valid) begin
                    ram_wen_d   = 1'b1;
                    ram_waddr_d = bitrev(cnt);
                    ram_wdata_d = {{HALF_WIDTH{1'b0}}, real_ext};
                    cnt_d       = cnt + ADDR_WIDTH'(1);
                    if (cnt == CNT_LAST) begin
                        state_d = START;
                    end
                end
            end
            START: begin
                if (!fft_start) begin
                    fft_start_d = 1'b1;
                end else begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (fft_done) begin
                    frame_cnt_d = frame_cnt + 16'd1;
                    state_d     = en ? LOAD : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d    = (state_d == BUSY);
        ram_sel_d = (state_d != BUSY);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            ram_wen   <= 1'b0;
            ram_waddr <= '0;
            ram_wdata <= '0;
            ram_sel   <= 1'b1;
            fft_start <= 1'b0;
            busy      <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            ram_wen   <= ram_wen_d;
            ram_waddr <= ram_waddr_d;
            ram_wdata <= ram_wdata_d;
            ram_sel   <= ram_sel_d;
            fft_start <= fft_start_d;
            busy      <= busy_d;
            frame_cnt <= frame_cnt_d;
        end
    end

endmodule

// File: doc/fft_sample_loader.md
# fft_sample_loader

Front-end stage of the FFT path. It accepts a stream of real-valued samples over a valid/ready handshake and writes each sample into the shared FFT working RAM at its bit-reversed address as {imag=0, real}. After a full frame of 2^ADDR_WIDTH samples it pulses `fft_start`, then holds off input until the FFT engine returns `fft_done`. It owns the RAM write port except while the FFT engine is computing.

## Interface
- `DATA_WIDTH`, default 16: input sample width, two's complement.
- `ADDR_WIDTH`, default 8: RAM address width; frame length N = 2^ADDR_WIDTH (256).
- `MUTI`, default 1: lane multiplier; each RAM half-word is MUTI*DATA_WIDTH bits.
- `IN_SHIFT`, default 0: arithmetic right shift applied to each sample for stage-growth headroom; legal range 0..DATA_WIDTH-1.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `en` in 1: loader enable.
- `s_data` in DATA_WIDTH: signed input sample.
- `s_valid` in 1: `s_data` is valid.
- `s_ready` out 1: loader accepts a sample this cycle.
- `ram_wen` out 1: RAM write strobe.
- `ram_waddr` out ADDR_WIDTH: RAM write address (bit-reversed).
- `ram_wdata` out 2*MUTI*DATA_WIDTH: write data, {imag, real}; imag in the upper half.
- `ram_sel` out 1: 1 = loader drives the RAM write port, 0 = FFT engine drives it.
- `fft_start` out 1: one-cycle start pulse to the FFT engine.
- `fft_done` in 1: one-cycle completion pulse from the FFT engine.
- `busy` out 1: FFT in progress (state BUSY).
- `frame_cnt` out 16: count of completed frames; wraps at 0xFFFF -> 0.

## Operation
- States: IDLE, LOAD, START, BUSY. Reset enters IDLE.
- IDLE: moves to LOAD on the next edge when `en`=1.
- LOAD: `s_ready` = 1. Sample counter `cnt` (ADDR_WIDTH bits) starts at 0.
  - On each accept (`s_valid & s_ready`): register `ram_wen`=1, `ram_waddr`=bitrev(cnt), and `ram_wdata` (format below); increment `cnt`.
  - An accept with cnt = N-1 moves to START and wraps cnt to 0.
- START: `fft_start` is registered high for exactly one cycle, then the FSM moves to BUSY.
- BUSY: `ram_sel`=0, `busy`=1, `s_ready`=0. On `fft_done`, increment `frame_cnt`, then go to LOAD if `en`=1, else IDLE.
- `s_ready` = (state==LOAD) & `en`. It is combinational from state and `en`; no combinational path from `s_valid`.
- `ram_sel` = 1 in IDLE, LOAD and START.
- Data format:
  - real half = sign-extend(s_data >>> IN_SHIFT) to MUTI*DATA_WIDTH bits.
  - imag half = 0.
  - `>>>` rounds toward minus infinity.
- bitrev: output bit i = cnt bit (ADDR_WIDTH-1-i).
- Boundary behaviour:
  - `en` falls in LOAD: partial frame is abandoned, cnt is cleared, FSM goes to IDLE on the next edge. A write already registered still completes.
  - `en` falls in START or BUSY: the frame completes normally, then FSM goes to IDLE.
  - `fft_done` outside BUSY: ignored; `frame_cnt` is unchanged.
  - `fft_done` coincident with the BUSY entry edge: ignored, because BUSY has not yet been entered.
  - `s_valid` held while `s_ready`=0: no write, no count change; the data must be held by the source.
  - Reset mid-frame: all state cleared; the RAM contents are don't-care.

## Timing
- Reset values:
  - `s_ready`=0, `ram_wen`=0, `ram_waddr`=0, `ram_wdata`=0.
  - `ram_sel`=1, `fft_start`=0, `busy`=0, `frame_cnt`=0.
  - FSM = IDLE, cnt = 0.
- Accept at edge k -> `ram_wen`/`ram_waddr`/`ram_wdata` valid during cycle k+1 (1-cycle latency). `ram_wen` is low in any cycle without a preceding accept.
- Final accept at edge k:
  - cycle k+1: last write, state=START, `s_ready`=0.
  - cycle k+2: `fft_start`=1.
  - cycle k+3: state=BUSY, `fft_start`=0, `ram_sel`=0, `busy`=1.
- `fft_done` sampled at edge j in BUSY:
  - cycle j+1: `frame_cnt` updated, `busy`=0, `ram_sel`=1, `s_ready`=1 if `en`=1.
- Throughput: one sample per clock in LOAD. Minimum frame overhead is 2 cycles plus the FFT time.

## Test plan
- Ramp `s_data`=0..255 with `s_valid` held high and `en`=1: writes occur at address 0 (0), 128 (1), 64 (2), 192 (3), 255 (255); `fft_start` pulses exactly once, 2 cycles after the last accept; `s_ready`=0 until `fft_done`.
- Gap/backpressure: toggle `s_valid` randomly, and assert `fft_done` 100 cycles after `fft_start`: exactly 256 writes occur; `frame_cnt`=1 the cycle after `fft_done`; the second frame is loaded and `frame_cnt`=2.
- IN_SHIFT=2:
  - `s_data`=-5 -> real half=0xFFFE (-2), imag half=0.
  - `s_data`=0x7FFF -> real half=0x1FFF.
  - With MUTI=2, real half = 32-bit sign extension.
- Drop `en` after 40 accepts: `s_ready` falls in the same cycle; FSM goes to IDLE; no `fft_start`. Re-raise `en`: the next sample is written to address 0.
- Pulse `fft_done` during LOAD: ignored; `frame_cnt` and state are unchanged.
- Assert `rst_n`=0 at sample 77: all outputs return to their reset values immediately; after release, the next frame starts at cnt 0.
